// File: rtl/imem_port_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | imem_port_arbiter_if                                                       |
// | Request/grant/read-valid bus used by each instruction-memory requester     |
// | and by the shared memory port.                                             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface imem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface
`default_nettype wire

// File: rtl/imem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | imem_port_arbiter                                                          |
// | Shares one instruction-memory port between CPU fetch (m0) and the          |
// | loader/debug master (m1); one access in flight, 1-cycle read latency.      |
// | Build option: IMEM_ARB_RR_EN selects round-robin tie-breaking, otherwise   |
// | m0 has fixed priority.                                                     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module imem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    imem_port_arbiter_if.slave     m0,
    imem_port_arbiter_if.slave     m1,
    imem_port_arbiter_if.master    mem
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_owner;
    logic              r_last_winner;
    logic              r_rd_pending;
    logic              r_m0_rvalid;
    logic              r_m1_rvalid;
    logic [DATA_W-1:0] r_m0_rdata;
    logic [DATA_W-1:0] r_m1_rdata;

    logic              w_any_req;
    logic              w_winner;
    logic              w_live;
    logic              w_issue;
    logic              w_we;
    logic              w_arb;
    logic              w_capture;

    assign w_any_req = m0.req | m1.req;

`ifdef IMEM_ARB_RR_EN
    assign w_winner = (m0.req & m1.req) ? ~r_last_winner : (m1.req & ~m0.req);
    logic w_unused;
    assign w_unused = &{1'b0, m0.we, m0.wdata, mem.gnt, mem.rvalid};
`else
    assign w_winner = ~m0.req;
    // Tie history is kept so both builds share one register map.
    logic w_unused;
    assign w_unused = &{1'b0, m0.we, m0.wdata, mem.gnt, mem.rvalid, r_last_winner};
`endif

    assign w_live    = r_owner ? m1.req : m0.req;
    assign w_we      = r_owner & m1.we;
    assign w_issue   = (r_state == ISSUE) & w_live;
    assign w_arb     = ((r_state == IDLE) | (r_state == RESP)) & w_any_req;
    assign w_capture = (r_state == RESP) & r_rd_pending;

    always_comb begin
        w_state_nxt = r_state;
        mem.req     = 1'b0;
        mem.we      = 1'b0;
        mem.addr    = '0;
        mem.wdata   = '0;
        m0.gnt      = 1'b0;
        m1.gnt      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any_req) w_state_nxt = ISSUE;
            end
            ISSUE: begin
                if (w_live) begin
                    mem.req     = 1'b1;
                    mem.we      = w_we;
                    mem.addr    = r_owner ? m1.addr : m0.addr;
                    mem.wdata   = r_owner ? m1.wdata : '0;
                    m0.gnt      = ~r_owner;
                    m1.gnt      = r_owner;
                    w_state_nxt = RESP;
                end else begin
                    // Requester withdrew before being granted: abort quietly.
                    w_state_nxt = IDLE;
                end
            end
            RESP: begin
                w_state_nxt = w_any_req ? ISSUE : IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_owner       <= 1'b0;
            r_last_winner <= 1'b1;
            r_rd_pending  <= 1'b0;
            r_m0_rvalid   <= 1'b0;
            r_m1_rvalid   <= 1'b0;
            r_m0_rdata    <= '0;
            r_m1_rdata    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_rd_pending <= w_issue & ~w_we;
            r_m0_rvalid  <= w_capture & ~r_owner;
            r_m1_rvalid  <= w_capture & r_owner;
            if (w_arb)                 r_owner       <= w_winner;
            if (w_issue)               r_last_winner <= r_owner;
            if (w_capture & ~r_owner)  r_m0_rdata    <= mem.rdata;
            if (w_capture & r_owner)   r_m1_rdata    <= mem.rdata;
        end
    end

    assign m0.rvalid = r_m0_rvalid;
    assign m0.rdata  = r_m0_rdata;
    assign m1.rvalid = r_m1_rvalid;
    assign m1.rdata  = r_m1_rdata;

endmodule
`default_nettype wire

// File: tb/tb_imem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_imem_port_arbiter                                                       |
// | Cycle-vector bench for imem_port_arbiter with a small word memory model.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_imem_port_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic mem_init = 1'b1;

    imem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0_bus ();
    imem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1_bus ();
    imem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mem_bus ();

    imem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .m0    (m0_bus),
        .m1    (m1_bus),
        .mem   (mem_bus)
    );

    always #5 clk = ~clk;

    // Word memory: word at byte address a holds 0xA000_0000 | a until written.
    logic [31:0] mem_arr [64];
    assign mem_bus.gnt    = 1'b0;
    assign mem_bus.rvalid = 1'b0;
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem_arr[i] <= 32'hA000_0000 | (32'(i) << 2);
            mem_bus.rdata <= '0;
        end else if (mem_bus.req) begin
            if (mem_bus.we) mem_arr[mem_bus.addr[7:2]] <= mem_bus.wdata;
            else            mem_bus.rdata <= mem_arr[mem_bus.addr[7:2]];
        end
    end

    typedef struct {
        string       name;
        logic        rn;
        logic        q0;
        logic [31:0] a0;
        logic        q1;
        logic        we1;
        logic [31:0] a1;
        logic [31:0] d1;
        logic [5:0]  ctl;   // {m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, mem_req, mem_we}
        logic [31:0] r0;
        logic [31:0] r1;
        logic [31:0] ma;
        logic [31:0] md;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [31:0] DB = 32'hDEAD_BEEF;
    localparam logic [31:0] A0 = 32'hA000_0000;
    localparam logic [31:0] A4 = 32'hA000_0004;
    localparam logic [31:0] A8 = 32'hA000_0008;
    localparam logic [31:0] AK = 32'hA000_0020;

    task automatic add(input string n, input logic rn, input logic q0, input logic [31:0] a0,
                       input logic q1, input logic we1, input logic [31:0] a1, input logic [31:0] d1,
                       input logic [5:0] ctl, input logic [31:0] r0, input logic [31:0] r1,
                       input logic [31:0] ma, input logic [31:0] md);
        vec_t v;
        v.name = n; v.rn = rn; v.q0 = q0; v.a0 = a0; v.q1 = q1; v.we1 = we1;
        v.a1 = a1; v.d1 = d1; v.ctl = ctl; v.r0 = r0; v.r1 = r1; v.ma = ma; v.md = md;
        vecs.push_back(v);
    endtask

    task automatic check(input string n, input logic [133:0] got, input logic [133:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, got, exp);
        end
    endtask

    logic [31:0] r1f;
    logic [133:0] got_v, exp_v;
    int lat_g, lat_v;
    logic [31:0] m1_got;
    logic m0_gnt_seen;

    initial begin
        m0_bus.req = 0; m0_bus.we = 0; m0_bus.addr = 0; m0_bus.wdata = 0;
        m1_bus.req = 0; m1_bus.we = 0; m1_bus.addr = 0; m1_bus.wdata = 0;

        // name        rn q0 a0     q1 we a1     d1      ctl        r0  r1   ma     md
        add("rst_a",    0, 1, 32'h4, 1, 1, 32'h20, 32'h55, 6'b000000, 0,  0,   0,     0);
        add("rst_b",    0, 0, 0,     1, 0, 32'h24, 0,      6'b000000, 0,  0,   0,     0);
        add("rst_c",    0, 0, 0,     0, 0, 0,      0,      6'b000000, 0,  0,   0,     0);
        add("rd4_idle", 1, 1, 32'h4, 0, 0, 0,      0,      6'b000000, 0,  0,   0,     0);
        add("rd4_iss",  1, 1, 32'h4, 0, 0, 0,      0,      6'b100010, 0,  0,   32'h4, 0);
        add("rd4_resp", 1, 0, 0,     0, 0, 0,      0,      6'b000000, 0,  0,   0,     0);
        add("rd4_rv",   1, 0, 0,     0, 0, 0,      0,      6'b010000, A4, 0,   0,     0);
        add("wr_idle",  1, 0, 0,     1, 1, 32'h10, DB,     6'b000000, A4, 0,   0,     0);
        add("wr_iss",   1, 0, 0,     1, 1, 32'h10, DB,     6'b001011, A4, 0,   32'h10, DB);
        add("wr_resp",  1, 0, 0,     0, 0, 0,      0,      6'b000000, A4, 0,   0,     0);
`ifdef IMEM_ARB_RR_EN
        add("rr_f0",    1, 1, 0, 1, 0, 32'h20, 0, 6'b000000, A4, 0,  0,      0);
        add("rr_f1",    1, 1, 0, 1, 0, 32'h20, 0, 6'b100010, A4, 0,  0,      0);
        add("rr_f2",    1, 1, 0, 1, 0, 32'h20, 0, 6'b000000, A4, 0,  0,      0);
        add("rr_f3",    1, 1, 0, 1, 0, 32'h20, 0, 6'b011010, A0, 0,  32'h20, 0);
        add("rr_f4",    1, 1, 0, 1, 0, 32'h20, 0, 6'b000000, A0, 0,  0,      0);
        add("rr_f5",    1, 1, 0, 1, 0, 32'h20, 0, 6'b100110, A0, AK, 0,      0);
        add("rr_f6",    1, 1, 0, 1, 0, 32'h20, 0, 6'b000000, A0, AK, 0,      0);
        add("rr_f7",    1, 1, 0, 1, 0, 32'h20, 0, 6'b011010, A0, AK, 32'h20, 0);
        add("rr_f8",    1, 0, 0, 0, 0, 0,      0, 6'b000000, A0, AK, 0,      0);
        add("rr_f9",    1, 0, 0, 0, 0, 0,      0, 6'b000100, A0, AK, 0,      0);
        r1f = AK;
`else
        add("fp_f0",    1, 1, 0, 1, 0, 32'h20, 0, 6'b000000, A4, 0, 0, 0);
        add("fp_f1",    1, 1, 0, 1, 0, 32'h20, 0, 6'b100010, A4, 0, 0, 0);
        add("fp_f2",    1, 1, 0, 1, 0, 32'h20, 0, 6'b000000, A4, 0, 0, 0);
        add("fp_f3",    1, 1, 0, 1, 0, 32'h20, 0, 6'b110010, A0, 0, 0, 0);
        add("fp_f4",    1, 1, 0, 1, 0, 32'h20, 0, 6'b000000, A0, 0, 0, 0);
        add("fp_f5",    1, 1, 0, 1, 0, 32'h20, 0, 6'b110010, A0, 0, 0, 0);
        add("fp_f6",    1, 1, 0, 1, 0, 32'h20, 0, 6'b000000, A0, 0, 0, 0);
        add("fp_f7",    1, 1, 0, 1, 0, 32'h20, 0, 6'b110010, A0, 0, 0, 0);
        add("fp_f8",    1, 0, 0, 0, 0, 0,      0, 6'b000000, A0, 0, 0, 0);
        add("fp_f9",    1, 0, 0, 0, 0, 0,      0, 6'b010000, A0, 0, 0, 0);
        r1f = 0;
`endif
        add("rb_idle",  1, 1, 32'h10, 0, 0, 0, 0, 6'b000000, A0, r1f, 0,      0);
        add("rb_iss",   1, 1, 32'h10, 0, 0, 0, 0, 6'b100010, A0, r1f, 32'h10, 0);
        add("rb_resp",  1, 0, 0,      0, 0, 0, 0, 6'b000000, A0, r1f, 0,      0);
        add("rb_rv",    1, 0, 0,      0, 0, 0, 0, 6'b010000, DB, r1f, 0,      0);
        add("ab_idle",  1, 1, 32'h8,  0, 0, 0, 0, 6'b000000, DB, r1f, 0,      0);
        add("ab_drop",  1, 0, 0,      0, 0, 0, 0, 6'b000000, DB, r1f, 0,      0);
        add("ab_reidl", 1, 1, 32'h8,  0, 0, 0, 0, 6'b000000, DB, r1f, 0,      0);
        add("ab_drop2", 1, 0, 0,      0, 0, 0, 0, 6'b000000, DB, r1f, 0,      0);
        add("bb_0",     1, 1, 32'h0,  0, 0, 0, 0, 6'b000000, DB, r1f, 0,      0);
        add("bb_1",     1, 1, 32'h0,  0, 0, 0, 0, 6'b100010, DB, r1f, 32'h0,  0);
        add("bb_2",     1, 1, 32'h4,  0, 0, 0, 0, 6'b000000, DB, r1f, 0,      0);
        add("bb_3",     1, 1, 32'h4,  0, 0, 0, 0, 6'b110010, A0, r1f, 32'h4,  0);
        add("bb_4",     1, 1, 32'h8,  0, 0, 0, 0, 6'b000000, A0, r1f, 0,      0);
        add("bb_5",     1, 1, 32'h8,  0, 0, 0, 0, 6'b110010, A4, r1f, 32'h8,  0);
        add("bb_6",     1, 0, 0,      0, 0, 0, 0, 6'b000000, A4, r1f, 0,      0);
        add("bb_7",     1, 0, 0,      0, 0, 0, 0, 6'b010000, A8, r1f, 0,      0);
        add("xr_idle",  1, 1, 32'hC,  0, 0, 0, 0, 6'b000000, A8, r1f, 0,      0);
        add("xr_iss",   1, 1, 32'hC,  0, 0, 0, 0, 6'b100010, A8, r1f, 32'hC,  0);
        add("xr_rst",   0, 0, 0,      0, 0, 0, 0, 6'b000000, 0,  0,   0,      0);
        add("xr_rel",   1, 0, 0,      0, 0, 0, 0, 6'b000000, 0,  0,   0,      0);
        add("xr_norv",  1, 0, 0,      0, 0, 0, 0, 6'b000000, 0,  0,   0,      0);

        @(negedge clk);
        @(negedge clk);
        mem_init = 1'b0;

        foreach (vecs[i]) begin
            rst_n        = vecs[i].rn;
            m0_bus.req   = vecs[i].q0;
            m0_bus.addr  = vecs[i].a0;
            m1_bus.req   = vecs[i].q1;
            m1_bus.we    = vecs[i].we1;
            m1_bus.addr  = vecs[i].a1;
            m1_bus.wdata = vecs[i].d1;
            #1;
            got_v = {m0_bus.gnt, m0_bus.rvalid, m1_bus.gnt, m1_bus.rvalid, mem_bus.req, mem_bus.we,
                     m0_bus.rdata, m1_bus.rdata, mem_bus.addr, mem_bus.wdata};
            exp_v = {vecs[i].ctl, vecs[i].r0, vecs[i].r1, vecs[i].ma, vecs[i].md};
            check(vecs[i].name, got_v, exp_v);
            @(negedge clk);
        end

        // M1 reads back the word it wrote before the reset: memory keeps its contents.
        lat_g = -1; lat_v = -1; m1_got = '0; m0_gnt_seen = 1'b0;
        m1_bus.req = 1; m1_bus.we = 0; m1_bus.addr = 32'h10; m1_bus.wdata = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (m0_bus.gnt) m0_gnt_seen = 1'b1;
            if (m1_bus.gnt && lat_g < 0) lat_g = c;
            if (m1_bus.rvalid && lat_v < 0) begin
                lat_v  = c;
                m1_got = m1_bus.rdata;
            end
            @(negedge clk);
            if (lat_g >= 0) m1_bus.req = 0;
        end
        check("m1_gnt_lat",   134'(lat_g),       134'(1));
        check("m1_rv_lat",    134'(lat_v),       134'(3));
        check("m1_rdata",     134'(m1_got),      134'(DB));
        check("m1_no_m0_gnt", 134'(m0_gnt_seen), 134'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
